// File: rtl/lsu_seq.sv
// Load/store sequencer: one access at a time over a req/gnt/rvalid word memory.
// Misaligned accesses become two aligned beats; load data is merged and extended.
module lsu_seq #(
  parameter bit SPLIT_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_size,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_BEAT0 = 3'd1;
  localparam logic [2:0] S_WAIT0 = 3'd2;
  localparam logic [2:0] S_BEAT1 = 3'd3;
  localparam logic [2:0] S_WAIT1 = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]  state_q, state_d;
  logic        we_q, two_beat_q, err_q;
  logic [2:0]  size_q;
  logic [31:0] addr_q, wdata_q, lo_q, rdata_q;

  logic        req_two_beat, req_illegal;
  logic [1:0]  off;
  logic [3:0]  base_mask;
  logic [7:0]  m8;
  logic [63:0] w64;
  logic [31:0] lo_src, d, ext;
  logic [23:0] hi_src;

  // NOTE: every signal written in an always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    req_two_beat = 1'b0;
    case (req_size[1:0])
      2'd1:    req_two_beat = (req_addr[1:0] == 2'd3);
      2'd2:    req_two_beat = (req_addr[1:0] != 2'd0);
      default: req_two_beat = 1'b0;
    endcase
    req_illegal = (req_size == 3'd3) || (req_size == 3'd6) || (req_size == 3'd7) ||
                  (req_we && req_size[2]) || (req_two_beat && !SPLIT_MISALIGNED);
  end

  assign off = addr_q[1:0];

  // Store lanes: shift data and byte mask across a 64-bit window spanning both beats.
  always_comb begin
    case (size_q[1:0])
      2'd0:    base_mask = 4'b0001;
      2'd1:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    m8  = {4'b0000, base_mask} << off;
    w64 = {32'd0, wdata_q} << {off, 3'b000};
  end

  // Load merge: the second beat supplies the upper bytes; single-beat uses zeros.
  always_comb begin
    lo_src = (state_q == S_WAIT1) ? lo_q : mem_rdata;
    hi_src = (state_q == S_WAIT1) ? mem_rdata[23:0] : 24'd0;
    case (off)
      2'd0:    d = lo_src;
      2'd1:    d = {hi_src[7:0],  lo_src[31:8]};
      2'd2:    d = {hi_src[15:0], lo_src[31:16]};
      default: d = {hi_src[23:0], lo_src[31:24]};
    endcase
    case (size_q)
      3'd0:    ext = {{24{d[7]}}, d[7:0]};
      3'd1:    ext = {{16{d[15]}}, d[15:0]};
      3'd4:    ext = {24'd0, d[7:0]};
      3'd5:    ext = {16'd0, d[15:0]};
      default: ext = d;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid)  state_d = req_illegal ? S_RESP : S_BEAT0;
      S_BEAT0: if (mem_gnt)    state_d = S_WAIT0;
      S_WAIT0: if (mem_rvalid) state_d = two_beat_q ? S_BEAT1 : S_RESP;
      S_BEAT1: if (mem_gnt)    state_d = S_WAIT1;
      S_WAIT1: if (mem_rvalid) state_d = S_RESP;
      S_RESP:  if (resp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      we_q       <= 1'b0;
      two_beat_q <= 1'b0;
      err_q      <= 1'b0;
      size_q     <= 3'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      lo_q       <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && req_valid) begin
        we_q       <= req_we;
        size_q     <= req_size;
        addr_q     <= req_addr;
        wdata_q    <= req_wdata;
        two_beat_q <= req_two_beat;
        err_q      <= req_illegal;
        rdata_q    <= 32'd0;
      end
      if (state_q == S_WAIT0 && mem_rvalid) begin
        lo_q <= mem_rdata;
        if (!two_beat_q) rdata_q <= we_q ? 32'd0 : ext;
      end
      if (state_q == S_WAIT1 && mem_rvalid) rdata_q <= we_q ? 32'd0 : ext;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = (state_q == S_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid & err_q;

  assign mem_req   = (state_q == S_BEAT0) || (state_q == S_BEAT1);
  assign mem_we    = mem_req & we_q;
  assign mem_addr  = !mem_req ? 32'd0 :
                     (state_q == S_BEAT1) ? {addr_q[31:2] + 30'd1, 2'b00} : {addr_q[31:2], 2'b00};
  assign mem_wdata = !mem_we ? 32'd0 : (state_q == S_BEAT1) ? w64[63:32] : w64[31:0];
  assign mem_wmask = !mem_we ? 4'd0  : (state_q == S_BEAT1) ? m8[7:4]    : m8[3:0];

endmodule

// File: tb/tb_lsu_seq.sv
// Self-checking bench for lsu_seq: byte-level memory model, directed cases, random traffic.
module tb_lsu_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_we = 0, resp_ready = 0;
  logic [2:0]  req_size = 0;
  logic [31:0] req_addr = 0, req_wdata = 0;
  logic        req_ready, resp_valid, resp_err, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;

  logic        n_req_valid = 0, n_req_we = 0, n_resp_ready = 0;
  logic [2:0]  n_req_size = 0;
  logic [31:0] n_req_addr = 0, n_req_wdata = 0;
  logic        n_req_ready, n_resp_valid, n_resp_err, n_mem_req, n_mem_we;
  logic [31:0] n_resp_rdata, n_mem_addr, n_mem_wdata;
  logic [3:0]  n_mem_wmask;
  logic        n_mem_gnt = 0, n_mem_rvalid = 0;
  logic [31:0] n_mem_rdata = 0;
  int          n_req_cnt = 0;

  lsu_seq #(.SPLIT_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err), .mem_req(mem_req),
    .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata));

  lsu_seq #(.SPLIT_MISALIGNED(1'b0)) dut_nosplit (
    .clk(clk), .rst_n(rst_n), .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we),
    .req_size(n_req_size), .req_addr(n_req_addr), .req_wdata(n_req_wdata), .resp_valid(n_resp_valid),
    .resp_ready(n_resp_ready), .resp_rdata(n_resp_rdata), .resp_err(n_resp_err), .mem_req(n_mem_req),
    .mem_gnt(n_mem_gnt), .mem_we(n_mem_we), .mem_addr(n_mem_addr), .mem_wdata(n_mem_wdata),
    .mem_wmask(n_mem_wmask), .mem_rvalid(n_mem_rvalid), .mem_rdata(n_mem_rdata));

  always @(posedge clk) if (n_mem_req) n_req_cnt++;

  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Word-addressed memory; unwritten words read back a fixed address-derived pattern.
  logic [31:0] mem [bit [29:0]];

  function automatic logic [31:0] rd_word(input logic [29:0] w);
    if (mem.exists(w)) return mem[w];
    return {w[13:0], 2'b01, w[15:0]} ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [7:0] byte_at(input logic [31:0] a);
    logic [31:0] w;
    w = rd_word(a[31:2]);
    return w[8*a[1:0] +: 8];
  endfunction

  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] mask; } beat_t;
  beat_t beats[$];

  int gnt_delay = 0, rv_delay = 0;
  bit stray = 0;

  // Memory responder: grants after gnt_delay held cycles, answers rv_delay cycles later.
  initial begin
    int wait_cnt, rv_cnt;
    bit pend;
    logic [31:0] pend_data, word, hold_addr, hold_wdata;
    logic [3:0] hold_mask;
    wait_cnt = 0; rv_cnt = 0; pend = 0; pend_data = 0;
    hold_addr = 0; hold_wdata = 0; hold_mask = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    forever begin
      @(negedge clk);
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
      if (!rst_n) begin
        pend = 0; wait_cnt = 0;
      end else if (stray) begin
        mem_rvalid = 1; mem_rdata = $urandom; stray = 0;
      end else if (pend) begin
        if (rv_cnt == 0) begin mem_rvalid = 1; mem_rdata = pend_data; pend = 0; end
        else rv_cnt--;
      end else if (mem_req) begin
        if (wait_cnt == 0) begin
          hold_addr = mem_addr; hold_wdata = mem_wdata; hold_mask = mem_wmask;
        end else begin
          check("gnt_hold_addr", mem_addr, hold_addr);
          check("gnt_hold_wdata", mem_wdata, hold_wdata);
          check("gnt_hold_mask", 32'(mem_wmask), 32'(hold_mask));
        end
        if (wait_cnt < gnt_delay) wait_cnt++;
        else begin
          wait_cnt = 0;
          mem_gnt = 1;
          beats.push_back('{mem_addr, mem_we, mem_wdata, mem_wmask});
          if (mem_we) begin
            word = rd_word(mem_addr[31:2]);
            for (int b = 0; b < 4; b++) if (mem_wmask[b]) word[8*b +: 8] = mem_wdata[8*b +: 8];
            mem[mem_addr[31:2]] = word;
          end
          pend_data = rd_word(mem_addr[31:2]);
          pend = 1;
          rv_cnt = rv_delay;
        end
      end
    end
  end

  task automatic do_access(input logic we, input logic [2:0] size, input logic [31:0] addr,
                           input logic [31:0] wdata, input int rr, output logic [31:0] rdata,
                           output logic err, output int lat);
    int n;
    beats.delete();
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    req_valid = 0;
    lat = 1;
    while (!resp_valid && lat < 100) begin @(negedge clk); lat++; end
    check("resp_valid_seen", 32'(resp_valid), 32'd1);
    rdata = resp_rdata;
    err = resp_err;
    for (int i = 0; i < rr; i++) begin
      @(negedge clk);
      check("resp_hold_valid", 32'(resp_valid), 32'd1);
      check("resp_hold_rdata", resp_rdata, rdata);
      check("resp_hold_err", 32'(resp_err), 32'(err));
    end
    resp_ready = 1;
    @(negedge clk);
    resp_ready = 0;
    check("resp_drop_valid", 32'(resp_valid), 32'd0);
    check("resp_drop_rdata", resp_rdata, 32'd0);
    check("req_ready_after", 32'(req_ready), 32'd1);
  endtask

  // Reference: byte-by-byte view of the access, independent of beat mechanics.
  task automatic run_op(input logic we, input logic [2:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gd, input int rd, input int rr,
                        output logic [31:0] rdata, output int lat);
    logic illegal, sgn, two, err;
    int nb, bt, nbeats;
    logic [31:0] exp_rdata, a, last, bm;
    logic [29:0] w0;
    logic [3:0] exp_mask [2];
    logic [31:0] exp_wdata [2];
    illegal = (size == 3'd3) || (size == 3'd6) || (size == 3'd7) ||
              (we && (size == 3'd4 || size == 3'd5));
    nb = (size[1:0] == 2'd0) ? 1 : (size[1:0] == 2'd1) ? 2 : 4;
    sgn = (size == 3'd0) || (size == 3'd1);
    w0 = addr[31:2];
    last = addr + 32'(nb - 1);
    two = (last[31:2] != w0);
    nbeats = illegal ? 0 : (two ? 2 : 1);
    exp_rdata = 0;
    exp_mask[0] = 0; exp_mask[1] = 0; exp_wdata[0] = 0; exp_wdata[1] = 0;
    for (int i = 0; i < nb; i++) begin
      a = addr + 32'(i);
      bt = (a[31:2] == w0) ? 0 : 1;
      if (we) begin
        exp_mask[bt][a[1:0]] = 1'b1;
        exp_wdata[bt][8*a[1:0] +: 8] = wdata[8*i +: 8];
      end else exp_rdata[8*i +: 8] = byte_at(a);
    end
    if (sgn) for (int i = nb; i < 4; i++) exp_rdata[8*i +: 8] = {8{exp_rdata[8*nb-1]}};
    if (we || illegal) exp_rdata = 0;
    gnt_delay = gd; rv_delay = rd;
    do_access(we, size, addr, wdata, rr, rdata, err, lat);
    check("resp_err", 32'(err), 32'(illegal));
    check("resp_rdata", rdata, exp_rdata);
    check("beat_count", 32'(beats.size()), 32'(nbeats));
    for (int b = 0; b < nbeats && b < beats.size(); b++) begin
      check("beat_addr", beats[b].addr, {w0 + 30'(b), 2'b00});
      check("beat_we", 32'(beats[b].we), 32'(we));
      check("beat_mask", 32'(beats[b].mask), 32'(exp_mask[b]));
      for (int k = 0; k < 4; k++) bm[8*k +: 8] = {8{exp_mask[b][k]}};
      check("beat_wdata", beats[b].wdata & bm, exp_wdata[b]);
    end
    if (we && !illegal)
      for (int i = 0; i < nb; i++) check("mem_byte", 32'(byte_at(addr + 32'(i))), 32'(wdata[8*i +: 8]));
  endtask

  task automatic nosplit_op(input logic [2:0] size, input logic [31:0] addr);
    int n;
    n = 0;
    n_req_valid = 1; n_req_we = 0; n_req_size = size; n_req_addr = addr;
    @(negedge clk);
    n_req_valid = 0;
    while (!n_resp_valid && n < 20) begin @(negedge clk); n++; end
    check("ns_resp_valid", 32'(n_resp_valid), 32'd1);
    check("ns_resp_err", 32'(n_resp_err), 32'd1);
    check("ns_resp_rdata", n_resp_rdata, 32'd0);
    n_resp_ready = 1;
    @(negedge clk);
    n_resp_ready = 0;
    check("ns_resp_drop", 32'(n_resp_valid), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat;
    logic [2:0] size_tab [10];
    size_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3, 3'd7};

    #1 rst_n = 0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wmask", 32'(mem_wmask), 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);

    mem[30'h40] = 32'hDEAD_BEEF;
    run_op(0, 3'd2, 32'h100, 0, 0, 0, 0, rd, lat);
    check("lw_aligned", rd, 32'hDEAD_BEEF);
    check("lw_latency", 32'(lat), 32'd3);

    mem[30'h40] = 32'h80FF_1234;
    run_op(0, 3'd0, 32'h103, 0, 0, 0, 0, rd, lat);
    check("lb_sign", rd, 32'hFFFF_FF80);
    run_op(0, 3'd4, 32'h103, 0, 0, 0, 0, rd, lat);
    check("lbu_zero", rd, 32'h0000_0080);
    run_op(0, 3'd5, 32'h102, 0, 0, 0, 0, rd, lat);
    check("lhu_zero", rd, 32'h0000_80FF);
    run_op(0, 3'd1, 32'h102, 0, 0, 0, 0, rd, lat);
    check("lh_sign", rd, 32'hFFFF_80FF);

    mem[30'h7F] = 32'hAABB_CCDD;
    mem[30'h80] = 32'h1122_3344;
    run_op(0, 3'd2, 32'h1FE, 0, 0, 0, 0, rd, lat);
    check("lw_split", rd, 32'h3344_AABB);

    run_op(1, 3'd2, 32'h0FFF_FFFD, 32'h1234_5678, 0, 0, 0, rd, lat);
    if (beats.size() == 2) begin
      check("sw_b0_mask", 32'(beats[0].mask), 32'hE);
      check("sw_b0_data", {8'd0, beats[0].wdata[31:8]}, 32'h0034_5678);
      check("sw_b1_addr", beats[1].addr, 32'h1000_0000);
      check("sw_b1_mask", 32'(beats[1].mask), 32'h1);
      check("sw_b1_data", 32'(beats[1].wdata[7:0]), 32'h12);
    end
    run_op(1, 3'd2, 32'hFFFF_FFFE, 32'hCAFE_F00D, 0, 0, 0, rd, lat);
    if (beats.size() == 2) check("sw_wrap_addr", beats[1].addr, 32'h0000_0000);

    run_op(0, 3'd1, 32'h201, 0, 5, 0, 3, rd, lat);
    check("gnt_hold_latency", 32'(lat), 32'd8);

    run_op(0, 3'd3, 32'h100, 0, 0, 0, 1, rd, lat);
    run_op(1, 3'd4, 32'h100, 32'h55, 0, 0, 0, rd, lat);

    nosplit_op(3'd1, 32'h3);
    nosplit_op(3'd2, 32'h2);
    check("ns_no_mem_req", 32'(n_req_cnt), 32'd0);

    // Reset while the first beat is outstanding, then a stray rvalid.
    gnt_delay = 0; rv_delay = 20;
    beats.delete();
    req_valid = 1; req_we = 0; req_size = 3'd2; req_addr = 32'h100;
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    check("mid_granted", 32'(beats.size()), 32'd1);
    check("mid_wait_no_req", 32'(mem_req), 32'd0);
    rst_n = 0;
    #1;
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_resp", 32'(resp_valid), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    stray = 1;
    rv_delay = 0;
    repeat (6) begin
      @(negedge clk);
      check("stray_resp_valid", 32'(resp_valid), 32'd0);
      check("stray_req_ready", 32'(req_ready), 32'd1);
      check("stray_mem_req", 32'(mem_req), 32'd0);
      check("stray_rdata", resp_rdata, 32'd0);
    end

    for (int k = 0; k < 60; k++) begin
      logic [31:0] base;
      base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 : 32'h0000_0400;
      run_op(1'($urandom_range(0, 1)), size_tab[$urandom_range(0, 9)],
             base + 32'($urandom_range(0, 31)), $urandom,
             $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2), rd, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_seq.md
Name: lsu_seq

Overview:
- Load/store sequencer between the pipeline memory stage and the single-port data memory.
- Accepts one access at a time and drives the memory req/gnt/rvalid handshake.
- Splits misaligned accesses into two aligned word beats, merges the returned words, then byte-extracts and sign/zero-extends load data.
- Generates store byte masks and lane-shifted write data.

Parameters:
- SPLIT_MISALIGNED, 1: 1 = split accesses that cross a word boundary into two beats; 0 = reject them with resp_err and no memory traffic.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous assert, active-low
- req_valid  in  1  pipeline access request
- req_ready  out  1  sequencer can accept (high only in IDLE)
- req_we  in  1  1 = store, 0 = load
- req_size  in  3  funct3 encoding: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU (the codebase LD_* macros carry these values)
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  access complete
- resp_ready  in  1  pipeline takes the response
- resp_rdata  out  32  extended load data; 0 for stores and errors
- resp_err  out  1  illegal size, or misaligned access with SPLIT_MISALIGNED=0
- mem_req  out  1  memory request
- mem_gnt  in  1  memory accepts the request this cycle
- mem_we  out  1  write enable
- mem_addr  out  32  word-aligned address (bits[1:0] = 0)
- mem_wdata  out  32  lane-aligned write data
- mem_wmask  out  4  byte enables
- mem_rvalid  in  1  one pulse per granted beat, loads and stores; mem_rdata valid on this pulse
- mem_rdata  in  32  read word

Behaviour:
- Reset: state IDLE; req_ready=1; all other outputs 0; capture registers cleared.
- States: IDLE, BEAT0, WAIT0, BEAT1, WAIT1, RESP.
- IDLE: req_valid=1 latches we, size, addr, wdata.
  - off = addr[1:0].
  - Beat count: 2 if (size half and off=3) or (size word and off≠0); otherwise 1.
- IDLE, illegal request: illegal = size ∈ {3,6,7}, or store with size ∈ {4,5}. Also treated as illegal: a 2-beat access with SPLIT_MISALIGNED=0. Go directly to RESP with resp_err=1 and no mem_req.
- IDLE, legal request: go to BEAT0.
- BEAT0/BEAT1:
  - mem_req=1, held with stable addr/we/wdata/wmask until mem_gnt.
  - On gnt go to WAIT0/WAIT1.
  - Beat0 address = {addr[31:2],2'b00}; beat1 address = beat0 + 4, wrapping 0xFFFFFFFC -> 0x00000000.
- WAIT0:
  - On mem_rvalid, capture rdata into lo.
  - Go to BEAT1 if 2 beats, else RESP.
- WAIT1: on mem_rvalid, capture rdata into hi and go to RESP.
- A response arriving in the same cycle as gnt is not possible (memory latency ≥1).
- Store lanes:
  - W64 = {32'b0,wdata} << (8*off).
  - M8 = base mask (1, 3 or F by size) << off.
  - Beat0 uses W64[31:0] and M8[3:0]; beat1 uses W64[63:32] and M8[7:4].
  - Loads drive mem_wmask=0.
- Load merge: D = {hi,lo} >> (8*off); hi=0 for single-beat.
  - Extend D[7:0] or D[15:0] by sign bit (size 0/1) or zeros (4/5).
  - Word returns D[31:0].
  - Registered into resp_rdata on entry to RESP.
- RESP:
  - resp_valid=1 with rdata/err stable until resp_ready.
  - Then go to IDLE; req_ready rises the next cycle, so there are no back-to-back accepts without a bubble.
- Minimum latency, aligned: accept at t, mem_req at t+1 (gnt at t+1), rvalid at t+2, resp_valid at t+3.
- rst_n low mid-operation: immediate return to IDLE with outputs cleared. A mem_rvalid arriving in IDLE/BEATx/RESP is ignored.
- resp_rdata/resp_err are 0 whenever resp_valid=0.

Test Plan:
- Aligned LW addr 0x100, mem returns 0xDEADBEEF -> mem_addr 0x100, mask 0, resp_rdata 0xDEADBEEF, resp_valid at accept+3 with gnt/rvalid immediate.
- LB addr 0x103, rdata 0x80FF1234 -> resp 0xFFFFFF80; LBU same -> 0x00000080; LHU addr 0x102 -> 0x000080FF.
- Misaligned LW addr 0x1FE, beats 0x1FC=0xAABBCCDD, 0x200=0x11223344 -> two mem_req at 0x1FC then 0x200, resp 0x3344AABB.
- SW addr 0x0FFFFFFD wdata 0x12345678 -> beat0 addr 0x0FFFFFFC mask 1110 wdata 0x345678xx; beat1 addr 0x10000000 mask 0001 wdata[7:0]=0x12. Addr 0xFFFFFFFE as a split store -> beat1 addr 0x00000000.
- mem_gnt withheld 5 cycles and resp_ready withheld 3 cycles -> mem_req/addr and resp_valid/rdata held stable throughout; size=3, and SPLIT_MISALIGNED=0 with LH at 0x3 -> resp_err=1, zero mem_req.
- rst_n pulsed low during WAIT0, then stray mem_rvalid after release -> outputs 0, req_ready=1, no resp_valid generated.
